register_bank_block: RTL and testbench

Decode-stage register bank for the 16-bit MIPS pipeline. It holds a 32 x 16-bit register file and writes the data-memory-stage result every clock. It supplies the two execute-stage operands A and B through forwarding multiplexers, with an immediate override on B. Both operands are registered, so the block also forms the ID/EX operand pipeline register.

---
 rtl/rb_pkg.sv | 45 ++++
 rtl/register_bank_block_if.sv | 33 +++
 rtl/regfile_32x16.sv | 49 ++++
 rtl/register_bank_block.sv | 50 +++++
 tb/tb_register_bank_block.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rb_pkg.sv
// Shared types and constants for the decode-stage register bank.
package rb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Operand source select, shared by the A and B forwarding muxes.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_DM  = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    // ID/EX operand pipeline payload.
    typedef struct packed {
        data_t a;
        data_t b;
    } operand_t;

    // Forwarding mux: register-file read or one of the later-stage results.
    function automatic data_t fwd_mux(
        input fwd_sel_t sel,
        input data_t    reg_val,
        input data_t    ex_val,
        input data_t    dm_val,
        input data_t    wb_val
    );
        data_t res;
        res = reg_val;
        case (sel)
            FWD_REG: res = reg_val;
            FWD_EX:  res = ex_val;
            FWD_DM:  res = dm_val;
            FWD_WB:  res = wb_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/register_bank_block_if.sv
// Pipeline-side bus of the register bank: stage results, addresses, selects
// and the registered operands.
interface register_bank_block_if;
    import rb_pkg::*;

    data_t       ans_ex;
    data_t       ans_dm;
    data_t       ans_wb;
    data_t       imm;
    addr_t       RA;
    addr_t       RB;
    addr_t       RW_dm;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;
    logic        imm_sel;
    data_t       A;
    data_t       B;

    modport master (
        output ans_ex, ans_dm, ans_wb, imm,
        output RA, RB, RW_dm,
        output mux_sel_A, mux_sel_B, imm_sel,
        input  A, B
    );

    modport slave (
        input  ans_ex, ans_dm, ans_wb, imm,
        input  RA, RB, RW_dm,
        input  mux_sel_A, mux_sel_B, imm_sel,
        output A, B
    );

endinterface

// File: rtl/regfile_32x16.sv
// 32 x 16-bit register file: one write port every clock, two combinational
// read ports returning pre-write contents.
// Option macro: RB_R0_ZERO_EN -- register 0 hardwired to zero.
module regfile_32x16
    import rb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t wr_addr,
    input  data_t wr_data,
    input  addr_t rd_addr_a,
    input  addr_t rd_addr_b,
    output data_t rd_data_a_c,
    output data_t rd_data_b_c
);

    data_t regs [NUM_REGS];

    // Storage: cleared on reset, unconditional write each edge otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
`ifdef RB_R0_ZERO_EN
            if (wr_addr != '0) begin
                regs[wr_addr] <= wr_data;
            end
`else
            regs[wr_addr] <= wr_data;
`endif
        end
    end

    // Read ports; same-cycle writes are not bypassed here (forwarding does it).
    always_comb begin
        rd_data_a_c = '0;
        rd_data_b_c = '0;
`ifdef RB_R0_ZERO_EN
        rd_data_a_c = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
        rd_data_b_c = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`else
        rd_data_a_c = regs[rd_addr_a];
        rd_data_b_c = regs[rd_addr_b];
`endif
    end

endmodule

// File: rtl/register_bank_block.sv
// Decode-stage register bank: register file, A/B forwarding muxes, immediate
// override on B and the ID/EX operand registers.
// Option macro: RB_R0_ZERO_EN (passed through to regfile_32x16).
module register_bank_block
    import rb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    register_bank_block_if.slave  bus
);

    data_t    rd_a_c;
    data_t    rd_b_c;
    operand_t opnd_d_c;
    operand_t opnd_q;

    regfile_32x16 u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_addr     (bus.RW_dm),
        .wr_data     (bus.ans_dm),
        .rd_addr_a   (bus.RA),
        .rd_addr_b   (bus.RB),
        .rd_data_a_c (rd_a_c),
        .rd_data_b_c (rd_b_c)
    );

    // Next operands: forwarding mux for A, immediate-or-forwarding for B.
    always_comb begin
        opnd_d_c   = '0;
        opnd_d_c.a = fwd_mux(fwd_sel_t'(bus.mux_sel_A), rd_a_c,
                             bus.ans_ex, bus.ans_dm, bus.ans_wb);
        opnd_d_c.b = bus.imm_sel ? bus.imm
                                 : fwd_mux(fwd_sel_t'(bus.mux_sel_B), rd_b_c,
                                           bus.ans_ex, bus.ans_dm, bus.ans_wb);
    end

    // ID/EX operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
        end else begin
            opnd_q <= opnd_d_c;
        end
    end

    assign bus.A = opnd_q.a;
    assign bus.B = opnd_q.b;

endmodule

// File: tb/tb_register_bank_block.sv
// Directed self-checking bench for register_bank_block.
module tb_register_bank_block;
    import rb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    register_bank_block_if bus ();

    register_bank_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ans_ex    = 16'h0000;
        bus.ans_dm    = 16'h0000;
        bus.ans_wb    = 16'h0000;
        bus.imm       = 16'h0000;
        bus.RA        = 5'd0;
        bus.RB        = 5'd0;
        bus.RW_dm     = 5'd31;
        bus.mux_sel_A = FWD_REG;
        bus.mux_sel_B = FWD_REG;
        bus.imm_sel   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ans_ex    = 16'h1111;
        bus.ans_dm    = 16'h5555;
        bus.ans_wb    = 16'h2222;
        bus.imm       = 16'hAAAA;
        bus.RA        = 5'd3;
        bus.RB        = 5'd9;
        bus.RW_dm     = 5'd3;
        bus.mux_sel_A = FWD_EX;
        bus.mux_sel_B = FWD_WB;
        bus.imm_sel   = 1'b1;
        step();
        step();
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL reset_A actual=%h expected=%h", bus.A, 16'h0000);
        end
        checks++;
        if (bus.B !== 16'h0000) begin
            failures++;
            $display("FAIL reset_B actual=%h expected=%h", bus.B, 16'h0000);
        end
        // Release; read regs 3 and 9 which must still hold zero.
        drive_idle();
        bus.RA = 5'd3;
        bus.RB = 5'd9;
        rst_n  = 1'b1;
        step();
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL reset_reg3 actual=%h expected=%h", bus.A, 16'h0000);
        end
        checks++;
        if (bus.B !== 16'h0000) begin
            failures++;
            $display("FAIL reset_reg9 actual=%h expected=%h", bus.B, 16'h0000);
        end
    endtask

    task automatic test_immediate();
        drive_idle();
        bus.RA      = 5'd5;
        bus.imm     = 16'hFFFF;
        bus.imm_sel = 1'b1;
        bus.RW_dm   = 5'd7;
        bus.ans_dm  = 16'hD000;
        step();
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL imm_A actual=%h expected=%h", bus.A, 16'h0000);
        end
        checks++;
        if (bus.B !== 16'hFFFF) begin
            failures++;
            $display("FAIL imm_B actual=%h expected=%h", bus.B, 16'hFFFF);
        end
        bus.imm_sel = 1'b0;
        bus.RB      = 5'd7;
        bus.RW_dm   = 5'd8;
        bus.ans_dm  = 16'h0BAD;
        step();
        checks++;
        if (bus.B !== 16'hD000) begin
            failures++;
            $display("FAIL imm_reg7 actual=%h expected=%h", bus.B, 16'hD000);
        end
    endtask

    task automatic test_forwarding();
        drive_idle();
        bus.ans_ex    = 16'hC000;
        bus.ans_dm    = 16'hD000;
        bus.ans_wb    = 16'hE000;
        bus.RW_dm     = 5'd7;
        bus.mux_sel_A = FWD_DM;
        bus.mux_sel_B = FWD_EX;
        step();
        checks++;
        if (bus.A !== 16'hD000) begin
            failures++;
            $display("FAIL fwd_dm_A actual=%h expected=%h", bus.A, 16'hD000);
        end
        checks++;
        if (bus.B !== 16'hC000) begin
            failures++;
            $display("FAIL fwd_ex_B actual=%h expected=%h", bus.B, 16'hC000);
        end
        bus.mux_sel_A = FWD_WB;
        bus.mux_sel_B = FWD_REG;
        bus.RB        = 5'd7;
        step();
        checks++;
        if (bus.A !== 16'hE000) begin
            failures++;
            $display("FAIL fwd_wb_A actual=%h expected=%h", bus.A, 16'hE000);
        end
        checks++;
        if (bus.B !== 16'hD000) begin
            failures++;
            $display("FAIL fwd_reg_B actual=%h expected=%h", bus.B, 16'hD000);
        end
    endtask

    task automatic test_read_during_write();
        drive_idle();
        bus.RW_dm  = 5'd3;
        bus.RA     = 5'd3;
        bus.RB     = 5'd3;
        bus.ans_dm = 16'h1234;
        step();
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL rdw_old_A actual=%h expected=%h", bus.A, 16'h0000);
        end
        checks++;
        if (bus.B !== 16'h0000) begin
            failures++;
            $display("FAIL rdw_old_B actual=%h expected=%h", bus.B, 16'h0000);
        end
        step();
        checks++;
        if (bus.A !== 16'h1234) begin
            failures++;
            $display("FAIL rdw_new_A actual=%h expected=%h", bus.A, 16'h1234);
        end
    endtask

    task automatic test_imm_priority();
        logic [15:0] imm_v;
        drive_idle();
        bus.ans_ex  = 16'h1EEE;
        bus.ans_dm  = 16'h2DDD;
        bus.ans_wb  = 16'h3BBB;
        bus.RB      = 5'd7;
        bus.imm_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imm_v         = 16'h0F00 + 16'(i * 17);
            bus.imm       = imm_v;
            bus.mux_sel_B = 2'(i);
            step();
            checks++;
            if (bus.B !== imm_v) begin
                failures++;
                $display("FAIL imm_prio_sel%0d actual=%h expected=%h", i, bus.B, imm_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        bus.RW_dm = 5'd10; bus.ans_dm = 16'hA00A; step();
        bus.RW_dm = 5'd11; bus.ans_dm = 16'hB00B; step();
        bus.RW_dm = 5'd12; bus.ans_dm = 16'hC00C; step();
        bus.RW_dm = 5'd31; bus.ans_dm = 16'h0000;
        bus.RA = 5'd10; bus.RB = 5'd11;
        step();
        checks++;
        if (bus.A !== 16'hA00A) begin
            failures++;
            $display("FAIL b2b_reg10 actual=%h expected=%h", bus.A, 16'hA00A);
        end
        checks++;
        if (bus.B !== 16'hB00B) begin
            failures++;
            $display("FAIL b2b_reg11 actual=%h expected=%h", bus.B, 16'hB00B);
        end
        bus.RA = 5'd12; bus.RB = 5'd10;
        step();
        checks++;
        if (bus.A !== 16'hC00C) begin
            failures++;
            $display("FAIL b2b_reg12 actual=%h expected=%h", bus.A, 16'hC00C);
        end
        checks++;
        if (bus.B !== 16'hA00A) begin
            failures++;
            $display("FAIL b2b_reg10_B actual=%h expected=%h", bus.B, 16'hA00A);
        end
    endtask

    task automatic test_r0();
        logic [15:0] exp_r0;
`ifdef RB_R0_ZERO_EN
        exp_r0 = 16'h0000;
`else
        exp_r0 = 16'hABCD;
`endif
        drive_idle();
        bus.RW_dm  = 5'd0;
        bus.ans_dm = 16'hABCD;
        step();
        bus.RW_dm  = 5'd1;
        bus.ans_dm = 16'h0000;
        bus.RA     = 5'd0;
        bus.RB     = 5'd0;
        step();
        checks++;
        if (bus.A !== exp_r0) begin
            failures++;
            $display("FAIL r0_read_A actual=%h expected=%h", bus.A, exp_r0);
        end
        checks++;
        if (bus.B !== exp_r0) begin
            failures++;
            $display("FAIL r0_read_B actual=%h expected=%h", bus.B, exp_r0);
        end
        // Forwarding with RA = 0 is never masked.
        bus.mux_sel_A = FWD_DM;
        bus.ans_dm    = 16'h5A5A;
        step();
        checks++;
        if (bus.A !== 16'h5A5A) begin
            failures++;
            $display("FAIL r0_fwd_A actual=%h expected=%h", bus.A, 16'h5A5A);
        end
    endtask

    task automatic test_mid_reset();
        drive_idle();
        bus.RW_dm  = 5'd4;
        bus.ans_dm = 16'h7777;
        bus.mux_sel_A = FWD_EX;
        bus.ans_ex = 16'h4444;
        bus.imm_sel = 1'b1;
        bus.imm = 16'h9999;
        step();
        // Assert reset mid-cycle: outputs must clear without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_A actual=%h expected=%h", bus.A, 16'h0000);
        end
        checks++;
        if (bus.B !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_B actual=%h expected=%h", bus.B, 16'h0000);
        end
        step();
        drive_idle();
        bus.RA = 5'd4;
        rst_n  = 1'b1;
        step();
        checks++;
        if (bus.A !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_reg4 actual=%h expected=%h", bus.A, 16'h0000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive_idle();
        test_reset();
        test_immediate();
        test_forwarding();
        test_read_during_write();
        test_imm_priority();
        test_back_to_back();
        test_r0();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
